// File: rtl/fir_pkg.sv
// Shared defaults and state encoding for the FIR feeder slice.
// Imported by the feeder top and its sample FIFO.
package fir_pkg;

  localparam int DEF_N_TAPS = 5;
  localparam int DEF_DATA_W = 8;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_LOAD   = 2'b01;
  localparam logic [1:0] ST_GAP    = 2'b10;
  localparam logic [1:0] ST_STREAM = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_LOAD   = ST_LOAD,
    S_GAP    = ST_GAP,
    S_STREAM = ST_STREAM
  } state_t;

endpackage

// File: rtl/fir_sample_fifo.sv
// Synchronous sample FIFO with occupancy, full and empty flags.
// Push while full is taken only when a pop happens on the same edge.
module fir_sample_fifo
  import fir_pkg::*;
#(
  parameter int W     = DEF_DATA_W,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_wdata,
  output logic [W-1:0]               o_rdata,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd];

  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/fir_feeder.sv
// Coefficient/sample sequencer for the FIR stage.
// Outputs are registered from next-state values so they align with state.
module fir_feeder
  import fir_pkg::*;
#(
  parameter int N_TAPS     = DEF_N_TAPS,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 8,
  parameter int SAMPLE_GAP = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            coef_wr_en,
  input  logic [$clog2(N_TAPS)-1:0]       coef_wr_addr,
  input  logic [DATA_W-1:0]               coef_wr_data,
  input  logic                            reload,
  input  logic                            s_valid,
  input  logic [DATA_W-1:0]               s_data,
  output logic                            s_ready,
  output logic [DATA_W-1:0]               data_out,
  output logic                            coef_enable,
  output logic                            sample_enable,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int AW = $clog2(N_TAPS);
  localparam int GW = (SAMPLE_GAP > 0) ? $clog2(SAMPLE_GAP+1) : 1;
  localparam int CW = $clog2(FIFO_DEPTH+1);

  logic [DATA_W-1:0] r_shadow [N_TAPS];
  logic [DATA_W-1:0] r_active [N_TAPS];
  logic [DATA_W-1:0] w_snap   [N_TAPS];

  state_t            r_state;
  state_t            w_nxt_state;
  logic [AW-1:0]     r_k;
  logic [AW-1:0]     w_nxt_k;
  logic [GW-1:0]     r_gap;
  logic [GW-1:0]     w_nxt_gap;
  logic              r_pend;
  logic              w_nxt_pend;
  logic              w_copy;
  logic              w_pop;
  logic              w_go;
  logic              w_wr_hit;
  logic              w_nxt_ce;
  logic              w_nxt_se;
  logic [DATA_W-1:0] w_nxt_data;

  logic [DATA_W-1:0] w_head;
  logic [CW-1:0]     w_count;
  logic              w_full;
  logic              w_empty;

  fir_sample_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (s_valid && s_ready),
    .i_pop   (w_pop),
    .i_wdata (s_data),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign s_ready    = !w_full;
  assign fifo_count = w_count;

  assign w_wr_hit = coef_wr_en && (int'(coef_wr_addr) < N_TAPS);
  assign w_go     = !w_empty && (r_gap == '0);

  // Same-edge host write is folded into the snapshot (write-first copy)
  always_comb begin
    for (int i = 0; i < N_TAPS; i++) begin
      w_snap[i] = r_shadow[i];
      if (w_wr_hit && int'(coef_wr_addr) == i) begin
        w_snap[i] = coef_wr_data;
      end
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_k     = r_k;
    w_nxt_pend  = r_pend;
    w_nxt_gap   = (r_gap != '0) ? r_gap - 1'b1 : r_gap;
    w_nxt_ce    = 1'b0;
    w_nxt_se    = 1'b0;
    w_nxt_data  = '0;
    w_copy      = 1'b0;
    w_pop       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_copy = reload;
      end
      S_LOAD: begin
        if (reload) begin
          w_nxt_pend = 1'b1;
        end
        if (r_k == AW'(N_TAPS-1)) begin
          w_nxt_state = S_GAP;
        end else begin
          w_nxt_k    = r_k + 1'b1;
          w_nxt_ce   = 1'b1;
          w_nxt_data = r_active[r_k + 1'b1];
        end
      end
      S_GAP: begin
        if (r_pend || reload) begin
          w_copy = 1'b1;
        end else begin
          w_nxt_state = S_STREAM;
          w_pop       = w_go;
        end
      end
      S_STREAM: begin
        if (reload) begin
          w_copy = 1'b1;
        end else begin
          w_pop = w_go;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
    if (w_copy) begin
      w_nxt_state = S_LOAD;
      w_nxt_k     = '0;
      w_nxt_pend  = 1'b0;
      w_nxt_ce    = 1'b1;
      w_nxt_data  = w_snap[0];
    end
    if (w_pop) begin
      w_nxt_se   = 1'b1;
      w_nxt_data = w_head;
      w_nxt_gap  = GW'(SAMPLE_GAP);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_TAPS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      if (w_wr_hit) begin
        r_shadow[coef_wr_addr] <= coef_wr_data;
      end
      if (w_copy) begin
        for (int i = 0; i < N_TAPS; i++) begin
          r_active[i] <= w_snap[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_k           <= '0;
      r_gap         <= '0;
      r_pend        <= 1'b0;
      data_out      <= '0;
      coef_enable   <= 1'b0;
      sample_enable <= 1'b0;
      busy          <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_k           <= w_nxt_k;
      r_gap         <= w_nxt_gap;
      r_pend        <= w_nxt_pend;
      data_out      <= w_nxt_data;
      coef_enable   <= w_nxt_ce;
      sample_enable <= w_nxt_se;
      busy          <= (w_nxt_state == S_LOAD) ||
                       (w_nxt_state == S_GAP);
    end
  end

endmodule

// File: tb/tb_fir_feeder.sv
// Directed bench for fir_feeder: loads, streaming, pending reload,
// full FIFO back-pressure and asynchronous reset.
module tb_fir_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic       coef_wr_en;
  logic [2:0] coef_wr_addr;
  logic [7:0] coef_wr_data;
  logic       reload;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic [7:0] data_out;
  logic       coef_enable;
  logic       sample_enable;
  logic       busy;
  logic [3:0] fifo_count;

  int n_tests = 0;
  int n_fail  = 0;

  fir_feeder dut (
    .clk           (clk),
    .reset         (reset),
    .coef_wr_en    (coef_wr_en),
    .coef_wr_addr  (coef_wr_addr),
    .coef_wr_data  (coef_wr_data),
    .reload        (reload),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .data_out      (data_out),
    .coef_enable   (coef_enable),
    .sample_enable (sample_enable),
    .busy          (busy),
    .fifo_count    (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int ce, input int se,
                         input int d, input int b);
    chk({tag, ".ce"}, 32'(coef_enable), 32'(ce));
    chk({tag, ".se"}, 32'(sample_enable), 32'(se));
    chk({tag, ".data"}, 32'(data_out), 32'(d));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("excl", 32'(coef_enable && sample_enable), 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    coef_wr_en   = 1'b0;
    coef_wr_addr = '0;
    coef_wr_data = '0;
    reload       = 1'b0;
    s_valid      = 1'b0;
    s_data       = '0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_out("rst", 0, 0, 0, 0);
    chk("rst.cnt", 32'(fifo_count), 32'd0);
    chk("rst.rdy", 32'(s_ready), 32'd1);
    reset = 1'b1;

    // FIFO fills while idle; s_ready drops on the 8th accept
    s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_data = 8'(100 + i);
      tick();
      chk("fill.cnt", 32'(fifo_count), (i < 8) ? i + 1 : 8);
      chk("fill.rdy", 32'(s_ready), (i < 7) ? 1 : 0);
    end
    s_valid = 1'b0;
    chk_out("idle", 0, 0, 0, 0);

    for (int i = 0; i < 5; i++) begin
      coef_wr_en   = 1'b1;
      coef_wr_addr = 3'(i);
      coef_wr_data = 8'(i + 1);
      tick();
    end
    coef_wr_en = 1'b0;

    reload = 1'b1;
    tick();
    reload = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk_out("load1", 1, 0, k + 1, 1);
      tick();
    end
    chk_out("gap1", 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_out("drain", 0, 1, 100 + i, 0);
    end
    tick();
    chk_out("drained", 0, 0, 0, 0);
    chk("drained.cnt", 32'(fifo_count), 32'd0);

    // Back-to-back samples in STREAM
    s_valid = 1'b1;
    s_data  = 8'd10;
    tick();
    chk("lat.se", 32'(sample_enable), 32'd0);
    chk("lat.cnt", 32'(fifo_count), 32'd1);
    s_data = 8'd20;
    tick();
    chk_out("s10", 0, 1, 10, 0);
    s_data = 8'd30;
    tick();
    chk_out("s20", 0, 1, 20, 0);
    s_valid = 1'b0;
    tick();
    chk_out("s30", 0, 1, 30, 0);
    chk("s30.cnt", 32'(fifo_count), 32'd0);
    tick();
    chk_out("s_end", 0, 0, 0, 0);

    // Reload plus coef write during the 3rd LOAD cycle
    reload = 1'b1;
    tick();
    reload = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk_out("ld_a", 1, 0, k + 1, 1);
      if (k == 2) begin
        reload       = 1'b1;
        coef_wr_en   = 1'b1;
        coef_wr_addr = 3'd0;
        coef_wr_data = 8'd9;
      end
      tick();
      reload     = 1'b0;
      coef_wr_en = 1'b0;
    end
    chk_out("gap_a", 0, 0, 0, 1);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk_out("ld_b", 1, 0, (k == 0) ? 9 : k + 1, 1);
      tick();
    end
    chk_out("gap_b", 0, 0, 0, 1);
    tick();
    chk_out("post_b", 0, 0, 0, 0);

    // Reload in STREAM with two samples queued: no pop on that edge
    s_valid = 1'b1;
    s_data  = 8'd40;
    tick();
    chk("q.cnt1", 32'(fifo_count), 32'd1);
    chk("q.se1", 32'(sample_enable), 32'd0);
    s_data = 8'd50;
    reload = 1'b1;
    tick();
    s_valid = 1'b0;
    reload  = 1'b0;
    chk("q.cnt2", 32'(fifo_count), 32'd2);
    for (int k = 0; k < 5; k++) begin
      chk_out("ld_c", 1, 0, (k == 0) ? 9 : k + 1, 1);
      tick();
    end
    chk_out("gap_c", 0, 0, 0, 1);
    chk("gap_c.cnt", 32'(fifo_count), 32'd2);
    tick();
    chk_out("q40", 0, 1, 40, 0);
    tick();
    chk_out("q50", 0, 1, 50, 0);
    chk("q50.cnt", 32'(fifo_count), 32'd0);

    // Asynchronous reset mid-STREAM with 4 samples queued
    reload = 1'b1;
    tick();
    reload  = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data = 8'(60 + i);
      tick();
    end
    s_valid = 1'b0;
    chk_out("gap_d", 0, 0, 0, 1);
    chk("gap_d.cnt", 32'(fifo_count), 32'd5);
    tick();
    chk_out("q60", 0, 1, 60, 0);
    chk("q60.cnt", 32'(fifo_count), 32'd4);
    #2 reset = 1'b0;
    #1;
    chk_out("arst", 0, 0, 0, 0);
    chk("arst.cnt", 32'(fifo_count), 32'd0);
    chk("arst.rdy", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;

    // Out-of-range write is dropped; bank reloads as zeros
    coef_wr_en   = 1'b1;
    coef_wr_addr = 3'd7;
    coef_wr_data = 8'hEE;
    tick();
    coef_wr_en = 1'b0;
    reload     = 1'b1;
    tick();
    reload = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk_out("ld_z", 1, 0, 0, 1);
      tick();
    end
    chk_out("gap_z", 0, 0, 0, 1);
    tick();
    chk_out("post_z", 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
